// File: rtl/mole_hole_if.sv
// Board/game-side bundle for the mole hole scheduler: game FSM inputs,
// whack buttons, hole LEDs, score display and hit/miss strobes.
interface mole_hole_if #(
  parameter int NUM_HOLES = 8,
  parameter int SCORE_W   = 8
);
  logic                 game_in_progress;
  logic                 mole_clk;
  logic [NUM_HOLES-1:0] whack_buttons;
  logic [NUM_HOLES-1:0] mole_leds;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   misses;
  logic                 hit_pulse;
  logic                 miss_pulse;

  // Game FSM / board side
  modport master (
    output game_in_progress, mole_clk, whack_buttons,
    input  mole_leds, score, misses, hit_pulse, miss_pulse
  );

  // Scheduler side
  modport slave (
    input  game_in_progress, mole_clk, whack_buttons,
    output mole_leds, score, misses, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/mole_hole_scheduler.sv
// Mole placement and scoring for the whack-a-mole game.
// Each mole_clk high window lights one pseudo-random hole (16-bit Galois LFSR),
// rising-edge whacks are scored as hits or misses, timeouts count as misses.
// Optional feature: define MOLE_NO_REPEAT_EN to forbid the same hole in two
// consecutive windows of one game.
module mole_hole_scheduler #(
  parameter int          NUM_HOLES = 8,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_button_pressed,
  mole_hole_if.slave bus
);
  localparam int              IDX_W     = $clog2(NUM_HOLES);
  localparam logic [15:0]     SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]     LFSR_MASK = 16'hB400;
  localparam logic [IDX_W:0]  NH_EXT    = (IDX_W+1)'(NUM_HOLES);
  localparam logic [IDX_W-1:0] NH_LOW   = IDX_W'(NUM_HOLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_UP = 2'd1;
  localparam logic [1:0] S_UP      = 2'd2;
  localparam logic [1:0] S_HIT     = 2'd3;

  logic [1:0]           state;
  logic [15:0]          lfsr;
  logic [NUM_HOLES-1:0] whack_q;
  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] leds_r;
  logic [SCORE_W-1:0]   score_r;
  logic [SCORE_W-1:0]   misses_r;
  logic                 hit_r;
  logic                 miss_r;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     hole_pick;
  logic [IDX_W-1:0]     hole_next;
  logic                 lit_press;
  logic                 unlit_press;
`ifdef MOLE_NO_REPEAT_EN
  localparam logic [IDX_W-1:0] TOP_HOLE = IDX_W'(NUM_HOLES - 1);
  logic [IDX_W-1:0]     last_hole;
  logic                 last_valid;
`endif

  // Counters stick at all ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [NUM_HOLES-1:0] one_hot(input logic [IDX_W-1:0] h);
    return NUM_HOLES'(1) << h;
  endfunction

  assign bus.mole_leds  = leds_r;
  assign bus.score      = score_r;
  assign bus.misses     = misses_r;
  assign bus.hit_pulse  = hit_r;
  assign bus.miss_pulse = miss_r;

  // Hole selection from the LFSR plus rising-edge press detection.
  always_comb begin
    idx       = lfsr[IDX_W-1:0];
    // idx is below 2*NUM_HOLES, so one conditional subtraction folds it into range.
    hole_pick = ({1'b0, idx} >= NH_EXT) ? idx - NH_LOW : idx;
    hole_next = hole_pick;
`ifdef MOLE_NO_REPEAT_EN
    if (last_valid && (hole_pick == last_hole))
      hole_next = (hole_pick == TOP_HOLE) ? '0 : hole_pick + IDX_W'(1);
`endif
    press       = bus.whack_buttons & ~whack_q;
    lit_press   = |(press & leds_r);
    unlit_press = |(press & ~leds_r);
  end

  // Free-running Galois LFSR, advances every cycle out of reset.
  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed)
      lfsr <= SEED_EFF;
    else
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  end

  // Button history in every state, so a held button is counted only once.
  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed)
      whack_q <= '0;
    else
      whack_q <= bus.whack_buttons;
  end

  // Game state machine with registered LEDs, counters and strobes.
  always_ff @(posedge clk or posedge reset_button_pressed) begin
    if (reset_button_pressed) begin
      state    <= S_IDLE;
      leds_r   <= '0;
      score_r  <= '0;
      misses_r <= '0;
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      last_hole  <= '0;
      last_valid <= 1'b0;
`endif
    end else begin
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state)
        S_IDLE: begin
          leds_r <= '0;
          if (bus.game_in_progress) begin
            score_r  <= '0;
            misses_r <= '0;
`ifdef MOLE_NO_REPEAT_EN
            last_valid <= 1'b0;
`endif
            state    <= S_WAIT_UP;
          end
        end
        S_WAIT_UP: begin
          leds_r <= '0;
          if (!bus.game_in_progress) begin
            state <= S_IDLE;
          end else if (bus.mole_clk) begin
            leds_r <= one_hot(hole_next);
`ifdef MOLE_NO_REPEAT_EN
            last_hole  <= hole_next;
            last_valid <= 1'b1;
`endif
            state  <= S_UP;
          end
        end
        S_UP: begin
          if (!bus.game_in_progress) begin
            // Game aborted: no scoring this cycle, counters kept for display.
            leds_r <= '0;
            state  <= S_IDLE;
          end else if (lit_press) begin
            // A lit-hole press wins over wrong presses and over the timeout.
            score_r <= sat_inc(score_r);
            hit_r   <= 1'b1;
            leds_r  <= '0;
            state   <= S_HIT;
          end else if (unlit_press || !bus.mole_clk) begin
            // At most one miss per cycle, whether wrong press or timeout.
            misses_r <= sat_inc(misses_r);
            miss_r   <= 1'b1;
            if (!bus.mole_clk) begin
              leds_r <= '0;
              state  <= S_WAIT_UP;
            end
          end
        end
        default: begin
          leds_r <= '0;
          if (!bus.game_in_progress)
            state <= S_IDLE;
          else if (!bus.mole_clk)
            state <= S_WAIT_UP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mole_hole_scheduler.sv
// Directed bench for mole_hole_scheduler at NUM_HOLES=5, SCORE_W=2.
// Expected holes come from a bench-side LFSR and hole-mapping model.
module tb_mole_hole_scheduler;
  localparam int NH = 5;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_hole_if #(.NUM_HOLES(NH), .SCORE_W(SW)) bus ();

  mole_hole_scheduler #(.NUM_HOLES(NH), .SCORE_W(SW), .LFSR_SEED(16'hACE1)) dut (
    .clk                 (clk),
    .reset_button_pressed(rst),
    .bus                 (bus)
  );

  int total = 0;
  int bad = 0;
  int prev_hole = -1;
  int repeats = 0;
  int h;
  logic [15:0] mdl_lfsr;

  // Reference LFSR: seed 16'hACE1, Galois mask 16'hB400, one shift per clock.
  always @(posedge clk or posedge rst) begin
    if (rst) mdl_lfsr <= 16'hACE1;
    else     mdl_lfsr <= mdl_lfsr[0] ? ((mdl_lfsr >> 1) ^ 16'hB400) : (mdl_lfsr >> 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT idle -> WAIT_UP with cleared counters.
  task automatic start_game();
    bus.game_in_progress = 1'b1;
    tick();
    prev_hole = -1;
    check("start_score", bus.score, 0);
    check("start_misses", bus.misses, 0);
  endtask

  // From WAIT_UP: raise mole_clk, predict the hole and check the lit LED.
  task automatic open_window(output int hole);
    int hh;
    hh = int'(mdl_lfsr[2:0]);
    if (hh >= NH) hh = hh - NH;
`ifdef MOLE_NO_REPEAT_EN
    if (prev_hole >= 0 && hh == prev_hole) hh = (hh == NH - 1) ? 0 : hh + 1;
`endif
    if (hh == prev_hole) repeats++;
    prev_hole = hh;
    hole = hh;
    bus.mole_clk = 1'b1;
    tick();
    check("leds_lit", bus.mole_leds, 32'(1) << hh);
  endtask

  task automatic window_timeout(input int exp_misses);
    int hw;
    open_window(hw);
    bus.mole_clk = 1'b0;
    tick();
    check("timeout_pulse", bus.miss_pulse, 1);
    check("timeout_misses", bus.misses, exp_misses);
    check("timeout_leds", bus.mole_leds, 0);
  endtask

  task automatic window_hit(input int exp_score);
    int hw;
    open_window(hw);
    bus.whack_buttons = 5'(1) << hw;
    tick();
    check("hit_pulse", bus.hit_pulse, 1);
    check("hit_score", bus.score, exp_score);
    check("hit_leds", bus.mole_leds, 0);
    bus.whack_buttons = '0;
    bus.mole_clk = 1'b0;
    tick();
    check("hit_pulse_once", bus.hit_pulse, 0);
  endtask

  initial begin
    bus.game_in_progress = 1'b0;
    bus.mole_clk = 1'b0;
    bus.whack_buttons = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", bus.mole_leds, 0);
    check("rst_score", bus.score, 0);
    check("rst_misses", bus.misses, 0);
    check("rst_hit", bus.hit_pulse, 0);
    check("rst_miss", bus.miss_pulse, 0);
    rst = 1'b0;

    // Idle with inputs low
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_leds", bus.mole_leds, 0);
    end
    check("idle_score", bus.score, 0);
    check("idle_miss_pulse", bus.miss_pulse, 0);

    // Hit at the fifth mole_clk cycle, button held afterwards
    start_game();
    open_window(h);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("leds_hold", bus.mole_leds, 32'(1) << h);
    end
    bus.whack_buttons = 5'(1) << h;
    tick();
    check("t2_hit_pulse", bus.hit_pulse, 1);
    check("t2_score", bus.score, 1);
    check("t2_leds_off", bus.mole_leds, 0);
    check("t2_misses", bus.misses, 0);
    tick();
    check("t2_held_no_pulse", bus.hit_pulse, 0);
    bus.whack_buttons = '0;
    repeat (13) tick();
    check("t2_hit_leds", bus.mole_leds, 0);
    bus.mole_clk = 1'b0;
    tick();
    check("t2_no_timeout_pulse", bus.miss_pulse, 0);
    check("t2_no_timeout_misses", bus.misses, 0);

    // Timeout miss, then restart and wrong-hole press followed by a hit
    window_timeout(1);
    tick();
    check("t3_miss_once", bus.miss_pulse, 0);
    bus.game_in_progress = 1'b0;
    tick();
    check("t3_idle_score_held", bus.score, 1);
    check("t3_idle_misses_held", bus.misses, 1);
    start_game();
    open_window(h);
    bus.whack_buttons = 5'(1) << ((h + 1) % NH);
    tick();
    check("t3_wrong_pulse", bus.miss_pulse, 1);
    check("t3_wrong_misses", bus.misses, 1);
    check("t3_wrong_leds_kept", bus.mole_leds, 32'(1) << h);
    bus.whack_buttons = '0;
    tick();
    check("t3_wrong_once", bus.miss_pulse, 0);
    bus.whack_buttons = 5'(1) << h;
    tick();
    check("t3_hit_score", bus.score, 1);
    check("t3_hit_misses", bus.misses, 1);
    bus.whack_buttons = '0;
    bus.mole_clk = 1'b0;
    tick();

    // Lit and unlit presses together: hit only
    open_window(h);
    bus.whack_buttons = (5'(1) << h) | (5'(1) << ((h + 2) % NH));
    tick();
    check("t4a_hit_pulse", bus.hit_pulse, 1);
    check("t4a_no_miss_pulse", bus.miss_pulse, 0);
    check("t4a_score", bus.score, 2);
    check("t4a_misses", bus.misses, 1);
    bus.whack_buttons = '0;
    bus.mole_clk = 1'b0;
    tick();

    // Lit press on the mole_clk falling cycle: hit, no timeout miss
    open_window(h);
    tick();
    bus.mole_clk = 1'b0;
    bus.whack_buttons = 5'(1) << h;
    tick();
    check("t4b_hit_pulse", bus.hit_pulse, 1);
    check("t4b_no_miss_pulse", bus.miss_pulse, 0);
    check("t4b_score", bus.score, 3);
    bus.whack_buttons = '0;
    tick();
    check("t4b_misses", bus.misses, 1);
    check("t4b_miss_pulse_after", bus.miss_pulse, 0);

    // Saturation of both counters with pulses still firing
    window_hit(3);
    window_hit(3);
    window_timeout(2);
    window_timeout(3);
    window_timeout(3);

    // Game dropped during UP, with a lit press in the same cycle
    open_window(h);
    bus.game_in_progress = 1'b0;
    bus.whack_buttons = 5'(1) << h;
    tick();
    check("t5_drop_leds", bus.mole_leds, 0);
    check("t5_drop_hit", bus.hit_pulse, 0);
    check("t5_drop_miss", bus.miss_pulse, 0);
    check("t5_drop_score", bus.score, 3);
    check("t5_drop_misses", bus.misses, 3);
    bus.whack_buttons = '0;
    tick();
    check("t5_idle_leds", bus.mole_leds, 0);
    check("t5_idle_misses", bus.misses, 3);
    bus.mole_clk = 1'b0;
    tick();

    // Asynchronous reset in the middle of a game
    start_game();
    window_hit(1);
    open_window(h);
    #3 rst = 1'b1;
    #1;
    check("arst_leds", bus.mole_leds, 0);
    check("arst_score", bus.score, 0);
    bus.mole_clk = 1'b0;
    bus.game_in_progress = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_idle_leds", bus.mole_leds, 0);

    // Long run of windows for hole range and repeat behaviour
    repeats = 0;
    start_game();
    for (int i = 0; i < 200; i++) begin
      window_timeout((i + 1 >= 3) ? 3 : i + 1);
    end
`ifdef MOLE_NO_REPEAT_EN
    check("no_repeats", repeats, 0);
`else
    check("repeat_seen", (repeats > 0) ? 1 : 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
